// File: rtl/horner_pkg.sv
// Shared types for the label packing path: label/word geometry, accumulator
// state encoding and the packed-word record carried through the output FIFO.
package horner_pkg;

  localparam int LABEL_W         = 8;
  localparam int LABELS_PER_WORD = 8;
  localparam int WORD_W          = LABEL_W * LABELS_PER_WORD;
  localparam int KEEP_W          = LABELS_PER_WORD;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DROP  = 2'd2
  } pack_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } pack_word_t;

  // Byte-enable mask for a word holding n labels (n = 1..8): (1<<n)-1.
  function automatic logic [KEEP_W-1:0] keep_mask(input logic [3:0] n);
    logic [KEEP_W:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[KEEP_W-1:0];
  endfunction

endpackage

// File: rtl/label_pack_fifo.sv
// First-word-fall-through FIFO of packed words. The head entry is presented on
// dout whenever the FIFO is not empty; dout reads as zero when empty so that a
// reset leaves every downstream output at 0. A push while full is accepted only
// when a pop happens in the same cycle, which keeps occupancy unchanged.
module label_pack_fifo
  import horner_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       push,
  input  logic       pop,
  input  pack_word_t din,
  output pack_word_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  pack_word_t      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because dout is masked when empty.
  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (depth is a power of two); occupancy kept separately.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/label_packer.sv
// Label packer: collects 8-bit classifier labels LSB-first into 64-bit AXIS
// words and queues them for the S2MM channel. Upstream cannot be stalled, so a
// word that finds the FIFO full (with no pop that cycle) is dropped, the rest
// of its frame is discarded, and the sticky overflow flag is raised.
// Optional feature macro: LABEL_CHECK_EN (illegal-label detection on bad_label).
//
// Handshake: the input side has no ready; every cycle with s_tvalid=1 is a beat.
// The output side is AXI-Stream: a word transfers on a rising edge where
// m_tvalid && m_tready; while m_tvalid && !m_tready the head word is held
// stable, and m_tvalid never depends on m_tready.
module label_packer
  import horner_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [IN_WIDTH-1:0]  s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic [7:0]           m_tkeep,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 overflow,
  output logic [31:0]          label_count,
  output logic                 bad_label,
  output pack_state_t          dbg_state
);

  pack_state_t       state;
  logic [WORD_W-1:0] acc_data;
  logic [2:0]        fill;
  logic              overflow_q;
  logic [31:0]       count_q;

  logic              beat;
  logic [3:0]        n_labels;
  logic [WORD_W-1:0] new_data;
  logic              word_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_push;
  logic              drop;
  pack_word_t        push_word;
  pack_word_t        head_word;

  // Beat decode and the word that would be pushed this cycle.
  always_comb begin
    beat      = s_tvalid && (state != DROP);
    n_labels  = {1'b0, fill} + 4'd1;
    new_data  = acc_data | (WORD_W'(s_tdata) << {fill, 3'b000});
    word_done = beat && ((fill == 3'd7) || s_tlast);
    fifo_pop  = !fifo_empty && m_tready;
    fifo_push = word_done && (!fifo_full || fifo_pop);
    drop      = word_done && fifo_full && !fifo_pop;
    push_word = '{data: new_data, keep: keep_mask(n_labels), last: s_tlast};
  end

  // Accumulator FSM with label counter and sticky overflow flag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= EMPTY;
      acc_data   <= '0;
      fill       <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state)
        EMPTY, FILL: begin
          if (s_tvalid) begin
            count_q <= count_q + 32'd1;
            if (word_done) begin
              acc_data <= '0;
              fill     <= '0;
              if (drop) begin
                overflow_q <= 1'b1;
                state      <= s_tlast ? EMPTY : DROP;
              end else begin
                state <= EMPTY;
              end
            end else begin
              acc_data <= new_data;
              fill     <= fill + 3'd1;
              state    <= FILL;
            end
          end
        end
        DROP: begin
          if (s_tvalid && s_tlast) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef LABEL_CHECK_EN
  logic bad_q;

  // Sticky flag for any accepted label outside 1..3; the label is still packed.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bad_q <= 1'b0;
    end else if (beat && ((s_tdata == '0) || (s_tdata > IN_WIDTH'(3)))) begin
      bad_q <= 1'b1;
    end
  end

  assign bad_label = bad_q;
`else
  assign bad_label = 1'b0;
`endif

  label_pack_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (push_word),
    .dout   (head_word),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_tdata     = head_word.data;
  assign m_tkeep     = head_word.keep;
  assign m_tlast     = head_word.last;
  assign m_tvalid    = !fifo_empty;
  assign overflow    = overflow_q;
  assign label_count = count_q;
  assign dbg_state   = state;

endmodule
